// File: rtl/risc8_pkg.sv
// Shared types and constants for the risc8 interrupt controller.
package risc8_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FIRE,
        SERVICE
    } intc_state_e;

    localparam logic [1:0] INTC_MASK = 2'd0;
    localparam logic [1:0] INTC_PEND = 2'd1;
    localparam logic [1:0] INTC_EOI  = 2'd2;
    localparam logic [1:0] INTC_STAT = 2'd3;

    localparam logic [7:0] INTC_VEC_BASE = 8'h80;

    // Lowest set index wins; source 0 has the highest priority.
    function automatic logic [2:0] intc_prio(input logic [7:0] req);
        logic [2:0] id;
        id = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) id = 3'(i);
        end
        return id;
    endfunction

endpackage

// File: rtl/risc8_intc_edge.sv
// Rising-edge detector for the interrupt lines.
// Optional 2-flop input synchronizer when RISC8_INTC_SYNC_EN is defined.
module risc8_intc_edge #(
    parameter int N_SRC = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_src,
    output logic [N_SRC-1:0] rise
);

    logic [N_SRC-1:0] sample;
    logic [N_SRC-1:0] prev_q;

`ifdef RISC8_INTC_SYNC_EN
    logic [N_SRC-1:0] sync_q1;
    logic [N_SRC-1:0] sync_q2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= irq_src;
            sync_q2 <= sync_q1;
        end
    end

    assign sample = sync_q2;
`else
    assign sample = irq_src;
`endif

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) prev_q <= '0;
        else     prev_q <= sample;
    end

    assign rise = sample & ~prev_q;

endmodule

// File: rtl/risc8_intc.sv
// risc8 interrupt controller: pending/mask registers, priority select, IDLE/FIRE/SERVICE FSM, com decode.
// Define RISC8_INTC_SYNC_EN to synchronize irq_src before edge detection.
module risc8_intc
    import risc8_pkg::*;
#(
    parameter int         N_SRC     = 8,
    parameter logic [7:0] BASE_ADDR = 8'hF0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_src,
    input  logic [7:0]       com_addr,
    input  logic [7:0]       com_wr,
    input  logic             com_wr_en,
    input  logic             com_rd_en,
    output logic [7:0]       com_rd,
    output logic             interrupt,
    output logic             in_service
);

    localparam logic [7:0] SRC_VALID = 8'((9'd1 << N_SRC) - 9'd1);

    intc_state_e      state_q, state_d;
    logic [7:0]       mask_q, pending_q, pending_d;
    logic [2:0]       active_id_q;
    logic [N_SRC-1:0] rise;
    logic [7:0]       rise_w, req, offset, status;
    logic [1:0]       reg_off;
    logic             sel, mask_wr, pend_wr, eoi_wr;

    risc8_intc_edge #(.N_SRC(N_SRC)) u_edge (
        .clk     (clk),
        .rst     (rst),
        .irq_src (irq_src),
        .rise    (rise)
    );

    assign offset  = com_addr - BASE_ADDR;
    assign sel     = (offset < 8'd4);
    assign reg_off = offset[1:0];
    assign mask_wr = com_wr_en && sel && (reg_off == INTC_MASK);
    assign pend_wr = com_wr_en && sel && (reg_off == INTC_PEND);
    assign eoi_wr  = com_wr_en && sel && (reg_off == INTC_EOI);
    assign req     = pending_q & mask_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        rise_w = '0;
        rise_w[N_SRC-1:0] = rise;
    end

    // Clears are applied before sets so a coincident edge always re-pends the bit.
    always_comb begin
        pending_d = pending_q;
        if (pend_wr) pending_d = pending_d & ~com_wr;
        if (state_q == FIRE) pending_d[active_id_q] = 1'b0;
        pending_d = (pending_d | rise_w) & SRC_VALID;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req != 8'h00) state_d = FIRE;
            FIRE:    state_d = SERVICE;
            SERVICE: if (eoi_wr) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mask_q      <= 8'h00;
            pending_q   <= 8'h00;
            active_id_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            if (mask_wr) mask_q <= com_wr & SRC_VALID;
            if (state_q == IDLE && req != 8'h00) active_id_q <= intc_prio(req);
        end
    end

    assign interrupt  = (state_q == FIRE);
    assign in_service = (state_q != IDLE);
    assign status     = {in_service, 4'b0000, active_id_q};

    always_comb begin
        com_rd = 8'h00;
        if (state_q == FIRE) begin
            com_rd = INTC_VEC_BASE | {5'b00000, active_id_q};
        end else if (com_rd_en && sel) begin
            case (reg_off)
                INTC_MASK: com_rd = mask_q;
                INTC_PEND: com_rd = pending_q;
                INTC_STAT: com_rd = status;
                default:   com_rd = 8'h00;
            endcase
        end
    end

endmodule
